// File: rtl/filtro_iir_secuencial_pkg.sv
// Shared constants for the sequential biquad: widths, coefficient selector
// codes, saturation limits and the controller state encoding.
package filtro_iir_secuencial_pkg;

    localparam int ANCHO  = 25;
    localparam int FRAC   = 14;
    localparam int PROD_W = 2 * ANCHO;
    localparam int ACC_W  = PROD_W + 3;

    localparam logic [2:0] SEL_A0 = 3'b000;
    localparam logic [2:0] SEL_A1 = 3'b001;
    localparam logic [2:0] SEL_A2 = 3'b010;
    localparam logic [2:0] SEL_B0 = 3'b011;
    localparam logic [2:0] SEL_B1 = 3'b100;
    localparam logic [2:0] SEL_B2 = 3'b101;

    localparam logic [ANCHO-1:0] SAT_MAX = 25'h0FFFFFF;
    localparam logic [ANCHO-1:0] SAT_MIN = 25'h1000000;

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        MAC0   = 3'd1,
        MAC1   = 3'd2,
        MAC2   = 3'd3,
        MAC3   = 3'd4,
        MAC4   = 3'd5,
        FIN    = 3'd6
    } estado_t;

    // Coefficient index each state needs; a0 is never used so it doubles as idle.
    function automatic logic [2:0] sel_de_estado(input estado_t e);
        logic [2:0] s;
        case (e)
            MAC0:    s = SEL_B0;
            MAC1:    s = SEL_B1;
            MAC2:    s = SEL_B2;
            MAC3:    s = SEL_A1;
            MAC4:    s = SEL_A2;
            default: s = SEL_A0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/filtro_iir_secuencial_mac_saturado.sv
// Multiply-accumulate unit: Q10.14 x Q10.14 product into a 53-bit accumulator
// (3 guard bits, five terms cannot overflow it), then rescale and clamp.
module filtro_iir_secuencial_mac_saturado
    import filtro_iir_secuencial_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             borrar,
    input  logic             acumular,
    input  logic             restar,
    input  logic [ANCHO-1:0] coef,
    input  logic [ANCHO-1:0] dato,
    output logic [ANCHO-1:0] y_sat
);

    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] dato_ext;
    logic signed [PROD_W-1:0] producto;
    logic signed [ACC_W-1:0]  termino;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  desplazado;
    logic                     cabe;

    assign coef_ext   = {{ANCHO{coef[ANCHO-1]}}, coef};
    assign dato_ext   = {{ANCHO{dato[ANCHO-1]}}, dato};
    assign producto   = coef_ext * dato_ext;
    assign termino    = {{(ACC_W-PROD_W){producto[PROD_W-1]}}, producto};
    assign desplazado = acc >>> FRAC;

    // The shifted value fits in ANCHO bits when every bit above the sign is a copy of it.
    assign cabe = (&desplazado[ACC_W-1:ANCHO-1]) | ~(|desplazado[ACC_W-1:ANCHO-1]);

    // Accumulator: cleared when a sample is accepted, add or subtract one product per MAC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (borrar) begin
            acc <= '0;
        end else if (acumular) begin
            acc <= restar ? (acc - termino) : (acc + termino);
        end
    end

    // Clamp the rescaled result to the Q10.14 range instead of letting it wrap.
    always_comb begin
        if (cabe) begin
            y_sat = desplazado[ANCHO-1:0];
        end else if (desplazado[ACC_W-1]) begin
            y_sat = SAT_MIN;
        end else begin
            y_sat = SAT_MAX;
        end
    end

endmodule

// File: rtl/filtro_iir_secuencial.sv
// Sequential Direct Form I biquad: one MAC per clock against the external
// coefficient table, one saturated output sample per accepted input.
//
//   state  | meaning
//   REPOSO | idle, waiting for dato_listo; latches x0 and clears acc on accept
//   MAC0   | acc += b0 * x0
//   MAC1   | acc += b1 * x1
//   MAC2   | acc += b2 * x2
//   MAC3   | acc -= a1 * y1
//   MAC4   | acc -= a2 * y2
//   FIN    | publish saturated y, shift histories
module filtro_iir_secuencial
    import filtro_iir_secuencial_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             dato_listo,
    input  logic [ANCHO-1:0] x_in,
    input  logic [ANCHO-1:0] Constantes,
    output logic [2:0]       selector,
    output logic [ANCHO-1:0] y_out,
    output logic             y_valido,
    output logic             ocupado
);

    estado_t          estado;
    estado_t          sig_estado;
    logic [ANCHO-1:0] x0;
    logic [ANCHO-1:0] x1;
    logic [ANCHO-1:0] x2;
    logic [ANCHO-1:0] y1;
    logic [ANCHO-1:0] y2;
    logic [ANCHO-1:0] operando;
    logic [ANCHO-1:0] y_sat;
    logic             acepta;
    logic             acumular;
    logic             restar;

    // State register; selector is registered from the next state so it is glitch-free for the whole MAC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado   <= REPOSO;
            selector <= SEL_A0;
        end else begin
            estado   <= sig_estado;
            selector <= sel_de_estado(sig_estado);
        end
    end

    // Next state: fixed walk through the five MACs; strobes outside REPOSO are dropped.
    always_comb begin
        sig_estado = estado;
        case (estado)
            REPOSO:  if (dato_listo) sig_estado = MAC0;
            MAC0:    sig_estado = MAC1;
            MAC1:    sig_estado = MAC2;
            MAC2:    sig_estado = MAC3;
            MAC3:    sig_estado = MAC4;
            MAC4:    sig_estado = FIN;
            FIN:     sig_estado = REPOSO;
            default: sig_estado = REPOSO;
        endcase
    end

    // Outputs and datapath control decoded from the current state.
    always_comb begin
        ocupado  = 1'b0;
        acepta   = 1'b0;
        acumular = 1'b0;
        restar   = 1'b0;
        operando = '0;
        case (estado)
            REPOSO: acepta = dato_listo;
            MAC0: begin
                ocupado  = 1'b1;
                acumular = 1'b1;
                operando = x0;
            end
            MAC1: begin
                ocupado  = 1'b1;
                acumular = 1'b1;
                operando = x1;
            end
            MAC2: begin
                ocupado  = 1'b1;
                acumular = 1'b1;
                operando = x2;
            end
            MAC3: begin
                ocupado  = 1'b1;
                acumular = 1'b1;
                restar   = 1'b1;
                operando = y1;
            end
            MAC4: begin
                ocupado  = 1'b1;
                acumular = 1'b1;
                restar   = 1'b1;
                operando = y2;
            end
            FIN:     ocupado = 1'b1;
            default: ocupado = 1'b0;
        endcase
    end

    // Sample capture, history shift and output publication; y1 keeps the saturated value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0       <= '0;
            x1       <= '0;
            x2       <= '0;
            y1       <= '0;
            y2       <= '0;
            y_out    <= '0;
            y_valido <= 1'b0;
        end else begin
            y_valido <= (estado == FIN);
            if (acepta) begin
                x0 <= x_in;
            end
            if (estado == FIN) begin
                x2    <= x1;
                x1    <= x0;
                y2    <= y1;
                y1    <= y_sat;
                y_out <= y_sat;
            end
        end
    end

    filtro_iir_secuencial_mac_saturado u_mac (
        .clk      (clk),
        .reset    (reset),
        .borrar   (acepta),
        .acumular (acumular),
        .restar   (restar),
        .coef     (Constantes),
        .dato     (operando),
        .y_sat    (y_sat)
    );

endmodule

// File: tb/tb_filtro_iir_secuencial.sv
`timescale 1ns/1ps
module tb_filtro_iir_secuencial;

    // Coefficient table (raw Q10.14). b0..b2 give impulse 3, 12, 22 for x=1.0;
    // 1 + a1 + a2 = 8 and b0 + b1 + b2 = 13, so DC gain is 13/8. Poles are real
    // and positive (about 0.996 and 0.879), so the step response rises monotonically.
    localparam longint A0 = 16384;
    localparam longint A1 = -30720;
    localparam longint A2 = 14344;
    localparam longint B0 = 3;
    localparam longint B1 = 7;
    localparam longint B2 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dato_listo = 1'b0;
    logic [24:0] x_in = '0;
    logic [24:0] Constantes;
    logic [2:0]  selector;
    logic [24:0] y_out;
    logic        y_valido;
    logic        ocupado;

    int          n_comp = 0;
    int          n_fallos = 0;
    int          ciclo = 0;
    int          n_pulsos = 0;
    int          modo_signo = 0;
    int          n_giros = 0;
    int          n_no_mono = 0;
    longint      y_prev = 0;
    logic [24:0] q_y[$];
    int          q_ciclo[$];
    longint      hx1, hx2, hy1, hy2;

    filtro_iir_secuencial dut (
        .clk        (clk),
        .reset      (reset),
        .dato_listo (dato_listo),
        .x_in       (x_in),
        .Constantes (Constantes),
        .selector   (selector),
        .y_out      (y_out),
        .y_valido   (y_valido),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    function automatic logic [24:0] tabla(input logic [2:0] s);
        longint c;
        case (s)
            3'd0:    c = A0;
            3'd1:    c = A1;
            3'd2:    c = A2;
            3'd3:    c = B0;
            3'd4:    c = B1;
            3'd5:    c = B2;
            default: c = 0;
        endcase
        return c[24:0];
    endfunction

    assign Constantes = tabla(selector);

    task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_fallos++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic limpiar_modelo();
        hx1 = 0;
        hx2 = 0;
        hy1 = 0;
        hy2 = 0;
    endtask

    // Reference biquad: exact integer arithmetic, floor shift, clamp.
    task automatic empujar(input logic [24:0] x);
        longint      xs;
        longint      acc;
        longint      y;
        logic [24:0] r;
        xs  = $signed(x);
        acc = B0 * xs + B1 * hx1 + B2 * hx2 - A1 * hy1 - A2 * hy2;
        y   = acc >>> 14;
        if (y > 64'sd16777215) y = 16777215;
        else if (y < -64'sd16777216) y = -16777216;
        r = y[24:0];
        q_y.push_back(r);
        q_ciclo.push_back(ciclo + 7);
        hx2 = hx1;
        hx1 = xs;
        hy2 = hy1;
        hy1 = y;
    endtask

    task automatic esperar(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; holds the strobe for one cycle.
    task automatic enviar(input logic [24:0] x, input bit acepta);
        dato_listo = 1'b1;
        x_in       = x;
        if (acepta) empujar(x);
        @(negedge clk);
        dato_listo = 1'b0;
    endtask

    task automatic reiniciar();
        comprobar("cola_vacia", q_y.size(), 0);
        reset = 1'b0;
        limpiar_modelo();
        q_y.delete();
        q_ciclo.delete();
        esperar(2);
        reset = 1'b1;
        esperar(1);
    endtask

    // Scoreboard: every y_valido pops one expected value and its expected cycle.
    always @(negedge clk) begin
        longint      yv;
        logic [24:0] esp;
        int          ce;
        if (y_valido) begin
            n_pulsos++;
            if (q_y.size() == 0) begin
                comprobar("y_valido_extra", 1, 0);
            end else begin
                esp = q_y.pop_front();
                ce  = q_ciclo.pop_front();
                comprobar("y_out", y_out, esp);
                comprobar("latencia", ciclo, ce);
            end
            yv = $signed(y_out);
            if (modo_signo > 0) begin
                if (y_out[24]) n_giros++;
                if (yv < y_prev) n_no_mono++;
            end else if (modo_signo < 0) begin
                if (!y_out[24]) n_giros++;
                if (yv > y_prev) n_no_mono++;
            end
            y_prev = yv;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sel_esp[7] = '{3, 4, 5, 1, 2, 0, 0};
        int          ocu_esp[7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [24:0] rnd;

        limpiar_modelo();
        esperar(3);
        comprobar("reset_selector", selector, 0);
        comprobar("reset_y_out", y_out, 0);
        comprobar("reset_y_valido", y_valido, 0);
        comprobar("reset_ocupado", ocupado, 0);
        reset = 1'b1;
        esperar(1);

        // Impulse with selector/ocupado trace on the first sample
        enviar(25'h0004000, 1'b1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            comprobar("traza_selector", selector, sel_esp[k]);
            comprobar("traza_ocupado", ocupado, ocu_esp[k]);
        end
        enviar(25'h0000000, 1'b1);
        esperar(6);
        enviar(25'h0000000, 1'b1);
        esperar(8);

        // Busy drop and FIN-cycle drop
        reiniciar();
        enviar(25'h0004000, 1'b1);
        esperar(2);
        enviar(25'h0FFFFFF, 1'b0);
        esperar(3);
        enviar(25'h0000000, 1'b1);
        esperar(5);
        enviar(25'h00ABCDE, 1'b0);
        enviar(25'h0000000, 1'b1);
        esperar(8);
        comprobar("drop_y_out", y_out, 25'h0000016);

        // Asynchronous reset during MAC2
        comprobar("cola_vacia", q_y.size(), 0);
        enviar(25'h0004000, 1'b1);
        esperar(2);
        comprobar("sel_mac2", selector, 5);
        #2 reset = 1'b0;
        #1;
        comprobar("rst_async_selector", selector, 0);
        comprobar("rst_async_y_out", y_out, 0);
        comprobar("rst_async_ocupado", ocupado, 0);
        comprobar("rst_async_y_valido", y_valido, 0);
        void'(q_y.pop_back());
        void'(q_ciclo.pop_back());
        limpiar_modelo();
        esperar(2);
        reset = 1'b1;
        esperar(1);
        enviar(25'h0004000, 1'b1);
        esperar(8);
        comprobar("post_rst_y_out", y_out, 25'h0000003);

        // Positive saturation
        reiniciar();
        modo_signo = 1;
        y_prev = 0;
        n_giros = 0;
        n_no_mono = 0;
        for (int i = 0; i < 500; i++) begin
            enviar(25'h0FFFFFF, 1'b1);
            esperar(6);
        end
        esperar(2);
        modo_signo = 0;
        comprobar("sat_max", y_out, 25'h0FFFFFF);
        comprobar("giros_pos", n_giros, 0);
        comprobar("monotono_pos", n_no_mono, 0);

        // Negative saturation
        reiniciar();
        modo_signo = -1;
        y_prev = 0;
        n_giros = 0;
        n_no_mono = 0;
        for (int i = 0; i < 500; i++) begin
            enviar(25'h1000000, 1'b1);
            esperar(6);
        end
        esperar(2);
        modo_signo = 0;
        comprobar("sat_min", y_out, 25'h1000000);
        comprobar("giros_neg", n_giros, 0);
        comprobar("monotono_neg", n_no_mono, 0);

        // Back-to-back random samples at full throughput
        reiniciar();
        n_pulsos = 0;
        for (int i = 0; i < 10; i++) begin
            rnd = 25'($urandom);
            enviar(rnd, 1'b1);
            esperar(6);
        end
        esperar(2);
        comprobar("pulsos_b2b", n_pulsos, 10);
        comprobar("cola_vacia_final", q_y.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_comp, n_fallos);
        $finish;
    end

endmodule
